// File: rtl/ulpi_reg_arb.sv
// ---------------------------------------------------------------------------
// ulpi_reg_arb
//
// Register-access arbiter and sequencer for a ULPI PHY. Two link-side
// requesters (req0: PHY init sequencer, req1: runtime config) share one
// transaction slot. A granted request is run as a ULPI TX CMD register write
// or register read on the 8-bit bus. If the PHY takes the bus (DIR) in the
// middle of a command, the transaction is aborted and re-issued after the bus
// turns around, up to MAX_RETRY attempts.
//
// Ports
//   i_clk, i_rst_n          ULPI 60 MHz clock, async active-low reset
//   i_reqN_valid/we/addr/wdata   request N (N = 0,1), held until o_reqN_ready
//   o_reqN_ready            1-cycle pulse: request latched
//   o_reqN_done             1-cycle pulse: transaction completed
//   o_reqN_err              1-cycle pulse: abandoned after MAX_RETRY aborts
//   o_reqN_rdata            read data, updated with o_reqN_done of a read
//   i_dir, i_nxt, i_data    ULPI DIR / NXT / data from PHY
//   o_data, o_stp           ULPI data to PHY / STP (pad driven when DIR = 0)
//   o_busy                  a transaction is latched (accept to done/err)
//
// All outputs are registered; inputs only feed next-state logic.
// ---------------------------------------------------------------------------
module ulpi_reg_arb #(
  parameter int MAX_RETRY = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,

  input  logic       i_req0_valid,
  input  logic       i_req0_we,
  input  logic [5:0] i_req0_addr,
  input  logic [7:0] i_req0_wdata,
  output logic       o_req0_ready,
  output logic       o_req0_done,
  output logic       o_req0_err,
  output logic [7:0] o_req0_rdata,

  input  logic       i_req1_valid,
  input  logic       i_req1_we,
  input  logic [5:0] i_req1_addr,
  input  logic [7:0] i_req1_wdata,
  output logic       o_req1_ready,
  output logic       o_req1_done,
  output logic       o_req1_err,
  output logic [7:0] o_req1_rdata,

  input  logic       i_dir,
  input  logic       i_nxt,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_stp,
  output logic       o_busy
);

  localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_WSTP,
    S_RD_WAIT,
    S_RD_DATA,
    S_BACKOFF
  } state_t;

  // Current-state registers
  state_t     state;
  logic       dir_q;       // DIR sampled on the previous cycle
  logic       rr_ptr;      // 0: favours req0 on contention, 1: favours req1
  logic [3:0] retry_cnt;
  logic       lat_id;
  logic       lat_we;
  logic [5:0] lat_addr;
  logic [7:0] lat_wdata;

  // Next-state values
  state_t     state_n;
  logic       rr_ptr_n;
  logic [3:0] retry_n;
  logic       lat_id_n;
  logic       lat_we_n;
  logic [5:0] lat_addr_n;
  logic [7:0] lat_wdata_n;
  logic [7:0] data_n;
  logic       stp_n;
  logic       busy_n;
  logic       ready0_n, ready1_n;
  logic       done0_n, done1_n;
  logic       err0_n, err1_n;
  logic [7:0] rdata0_n, rdata1_n;

  // Combinational helpers
  logic       bus_free;
  logic       abort;
  logic       grant_id;
  logic       grant_we;
  logic [5:0] grant_addr;
  logic [7:0] txcmd;

  // The bus is ours only after DIR has been low for two consecutive samples,
  // which also covers the turnaround cycle after the PHY releases the bus.
  assign bus_free = !i_dir && !dir_q;

  // TX CMD byte for the latched request: 10aaaaaa = RegWrite, 11aaaaaa = RegRead
  assign txcmd = {(lat_we ? 2'b10 : 2'b11), lat_addr};

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    retry_n     = retry_cnt;
    lat_id_n    = lat_id;
    lat_we_n    = lat_we;
    lat_addr_n  = lat_addr;
    lat_wdata_n = lat_wdata;
    data_n      = o_data;
    stp_n       = o_stp;
    busy_n      = o_busy;
    ready0_n    = 1'b0;
    ready1_n    = 1'b0;
    done0_n     = 1'b0;
    done1_n     = 1'b0;
    err0_n      = 1'b0;
    err1_n      = 1'b0;
    rdata0_n    = o_req0_rdata;
    rdata1_n    = o_req1_rdata;
    abort       = 1'b0;
    grant_id    = 1'b0;
    grant_we    = 1'b0;
    grant_addr  = '0;

    case (state)
      S_IDLE: begin
        if (bus_free && (i_req0_valid || i_req1_valid)) begin
          // Contention goes to the favoured requester; otherwise the lone one.
          grant_id    = (i_req0_valid && i_req1_valid) ? rr_ptr : i_req1_valid;
          grant_we    = grant_id ? i_req1_we   : i_req0_we;
          grant_addr  = grant_id ? i_req1_addr : i_req0_addr;
          lat_id_n    = grant_id;
          lat_we_n    = grant_we;
          lat_addr_n  = grant_addr;
          lat_wdata_n = grant_id ? i_req1_wdata : i_req0_wdata;
          rr_ptr_n    = ~grant_id;
          retry_n     = '0;
          busy_n      = 1'b1;
          ready0_n    = !grant_id;
          ready1_n    = grant_id;
          data_n      = {(grant_we ? 2'b10 : 2'b11), grant_addr};
          state_n     = S_CMD;
        end
      end

      S_CMD: begin
        // DIR wins over a simultaneous NXT: the PHY has taken the bus.
        if (i_dir) begin
          abort = 1'b1;
        end else if (i_nxt) begin
          if (lat_we) begin
            data_n  = lat_wdata;
            state_n = S_WDATA;
          end else begin
            data_n  = '0;
            state_n = S_RD_WAIT;
          end
        end
      end

      S_WDATA: begin
        if (i_dir) begin
          abort = 1'b1;
        end else if (i_nxt) begin
          data_n  = '0;
          stp_n   = 1'b1;
          state_n = S_WSTP;
        end
      end

      S_WSTP: begin
        stp_n   = 1'b0;
        busy_n  = 1'b0;
        done0_n = !lat_id;
        done1_n = lat_id;
        state_n = S_IDLE;
      end

      S_RD_WAIT: begin
        // First DIR-high cycle is the turnaround; data follows next cycle.
        if (i_dir) begin
          state_n = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        // NXT here means the PHY is sending RX CMD / receive data instead of
        // the register value.
        if (i_nxt) begin
          abort = 1'b1;
        end else begin
          if (lat_id) begin
            rdata1_n = i_data;
          end else begin
            rdata0_n = i_data;
          end
          busy_n  = 1'b0;
          done0_n = !lat_id;
          done1_n = lat_id;
          state_n = S_IDLE;
        end
      end

      S_BACKOFF: begin
        // Re-issue the latched command without re-arbitrating.
        if (bus_free) begin
          data_n  = txcmd;
          state_n = S_CMD;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort) begin
      data_n  = '0;
      stp_n   = 1'b0;
      retry_n = retry_cnt + 4'd1;
      if (retry_n == MAX_RETRY_W) begin
        busy_n  = 1'b0;
        err0_n  = !lat_id;
        err1_n  = lat_id;
        state_n = S_IDLE;
      end else begin
        state_n = S_BACKOFF;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      dir_q        <= 1'b0;
      rr_ptr       <= 1'b0;
      retry_cnt    <= '0;
      lat_id       <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      o_data       <= '0;
      o_stp        <= 1'b0;
      o_busy       <= 1'b0;
      o_req0_ready <= 1'b0;
      o_req1_ready <= 1'b0;
      o_req0_done  <= 1'b0;
      o_req1_done  <= 1'b0;
      o_req0_err   <= 1'b0;
      o_req1_err   <= 1'b0;
      o_req0_rdata <= '0;
      o_req1_rdata <= '0;
    end else begin
      state        <= state_n;
      dir_q        <= i_dir;
      rr_ptr       <= rr_ptr_n;
      retry_cnt    <= retry_n;
      lat_id       <= lat_id_n;
      lat_we       <= lat_we_n;
      lat_addr     <= lat_addr_n;
      lat_wdata    <= lat_wdata_n;
      o_data       <= data_n;
      o_stp        <= stp_n;
      o_busy       <= busy_n;
      o_req0_ready <= ready0_n;
      o_req1_ready <= ready1_n;
      o_req0_done  <= done0_n;
      o_req1_done  <= done1_n;
      o_req0_err   <= err0_n;
      o_req1_err   <= err1_n;
      o_req0_rdata <= rdata0_n;
      o_req1_rdata <= rdata1_n;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_arb.sv
// ---------------------------------------------------------------------------
// tb_ulpi_reg_arb
//
// Directed bench for ulpi_reg_arb. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge. tick() advances
// one cycle and tallies ready/done/err/STP pulses and the grant order.
// ---------------------------------------------------------------------------
module tb_ulpi_reg_arb;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req0_valid, i_req0_we;
  logic [5:0] i_req0_addr;
  logic [7:0] i_req0_wdata;
  logic       o_req0_ready, o_req0_done, o_req0_err;
  logic [7:0] o_req0_rdata;
  logic       i_req1_valid, i_req1_we;
  logic [5:0] i_req1_addr;
  logic [7:0] i_req1_wdata;
  logic       o_req1_ready, o_req1_done, o_req1_err;
  logic [7:0] o_req1_rdata;
  logic       i_dir, i_nxt;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_stp, o_busy;

  ulpi_reg_arb #(.MAX_RETRY(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_we    (i_req0_we),
    .i_req0_addr  (i_req0_addr),
    .i_req0_wdata (i_req0_wdata),
    .o_req0_ready (o_req0_ready),
    .o_req0_done  (o_req0_done),
    .o_req0_err   (o_req0_err),
    .o_req0_rdata (o_req0_rdata),
    .i_req1_valid (i_req1_valid),
    .i_req1_we    (i_req1_we),
    .i_req1_addr  (i_req1_addr),
    .i_req1_wdata (i_req1_wdata),
    .o_req1_ready (o_req1_ready),
    .o_req1_done  (o_req1_done),
    .o_req1_err   (o_req1_err),
    .o_req1_rdata (o_req1_rdata),
    .i_dir        (i_dir),
    .i_nxt        (i_nxt),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_stp        (o_stp),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  int r0_cnt = 0, r1_cnt = 0;
  int d0_cnt = 0, d1_cnt = 0;
  int e0_cnt = 0, e1_cnt = 0;
  int stp_cnt = 0;
  int grants[$];
  logic gap_armed = 1'b0;
  logic busy_low_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    if (o_req0_ready || o_req1_ready) begin
      grants.push_back(int'(o_req1_ready));
      // Consecutive grants must have an idle (not busy) cycle between them.
      if (gap_armed) check("idle_gap_between_grants", busy_low_seen, 1);
      gap_armed     = 1'b1;
      busy_low_seen = 1'b0;
    end else if (!o_busy) begin
      busy_low_seen = 1'b1;
    end
    if (o_req0_ready) r0_cnt++;
    if (o_req1_ready) r1_cnt++;
    if (o_req0_done)  d0_cnt++;
    if (o_req1_done)  d1_cnt++;
    if (o_req0_err)   e0_cnt++;
    if (o_req1_err)   e1_cnt++;
    if (o_stp)        stp_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0s, r1s, d0s, d1s, e1s, stps, gs, cmds;
    logic err_busy;

    i_rst_n = 1'b0;
    i_req0_valid = 0; i_req0_we = 0; i_req0_addr = '0; i_req0_wdata = '0;
    i_req1_valid = 0; i_req1_we = 0; i_req1_addr = '0; i_req1_wdata = '0;
    i_dir = 0; i_nxt = 0; i_data = '0;

    // ---------------- reset values ----------------
    tick(); tick();
    check("rst_data",  o_data, 8'h00);
    check("rst_stp",   o_stp, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_ready", {o_req0_ready, o_req1_ready}, 2'b00);
    check("rst_done",  {o_req0_done, o_req1_done}, 2'b00);
    check("rst_err",   {o_req0_err, o_req1_err}, 2'b00);
    check("rst_rdata", {o_req0_rdata, o_req1_rdata}, 16'h0000);
    i_rst_n = 1'b1;
    tick();

    // ---------------- write req0 0x0A <- 0x55 ----------------
    r0s = r0_cnt; d0s = d0_cnt; stps = stp_cnt;
    i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 6'h0A; i_req0_wdata = 8'h55;
    tick();
    check("w_ready0", o_req0_ready, 1);
    check("w_busy",   o_busy, 1);
    check("w_txcmd",  o_data, 8'h8A);
    i_req0_valid = 0;
    tick();                              // CMD, PHY not ready yet
    check("w_ready_pulse", o_req0_ready, 0);
    check("w_txcmd_hold",  o_data, 8'h8A);
    i_nxt = 1;
    tick();
    check("w_wdata", o_data, 8'h55);
    check("w_wdata_stp", o_stp, 0);
    tick();
    check("w_stp",      o_stp, 1);
    check("w_stp_data", o_data, 8'h00);
    i_nxt = 0;
    tick();
    check("w_done0",    o_req0_done, 1);
    check("w_stp_fall", o_stp, 0);
    check("w_busy_fall", o_busy, 0);
    tick();
    check("w_ready0_count", r0_cnt - r0s, 1);
    check("w_done0_count",  d0_cnt - d0s, 1);
    check("w_stp_count",    stp_cnt - stps, 1);

    // ---------------- read req1 0x04 -> 0x24 ----------------
    i_req1_valid = 1; i_req1_we = 0; i_req1_addr = 6'h04;
    tick();
    check("r_ready1", o_req1_ready, 1);
    check("r_txcmd",  o_data, 8'hC4);
    i_req1_valid = 0; i_nxt = 1;
    tick();                              // RD_WAIT
    check("r_wait_data", o_data, 8'h00);
    i_nxt = 0; i_dir = 1;                // turnaround
    tick();                              // RD_DATA
    check("r_turn_data", o_data, 8'h00);
    check("r_no_early_done", o_req1_done, 0);
    i_data = 8'h24;
    tick();
    check("r_done1", o_req1_done, 1);
    check("r_rdata1", o_req1_rdata, 8'h24);
    check("r_busy_fall", o_busy, 0);
    check("r_dir_data", o_data, 8'h00);
    i_dir = 0; i_data = 8'h00;
    tick();
    check("r_rdata1_held", o_req1_rdata, 8'h24);
    check("r_rdata0_untouched", o_req0_rdata, 8'h00);

    // ---------------- both valid, four grants alternate ----------------
    gs = grants.size(); d0s = d0_cnt; d1s = d1_cnt;
    i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 6'h01; i_req0_wdata = 8'h10;
    i_req1_valid = 1; i_req1_we = 1; i_req1_addr = 6'h02; i_req1_wdata = 8'h20;
    i_nxt = 1;
    for (int i = 0; i < 80 && (d0_cnt - d0s + d1_cnt - d1s) < 4; i++) begin
      tick();
      if (grants.size() - gs >= 4) begin
        i_req0_valid = 0; i_req1_valid = 0;
      end
    end
    i_nxt = 0;
    tick();
    check("rr_grant_count", grants.size() - gs, 4);
    check("rr_done_count", d0_cnt - d0s + d1_cnt - d1s, 4);
    if (grants.size() >= gs + 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), grants[gs + k], k % 2);
    end

    // ---------------- two aborts in CMD, then success ----------------
    r0s = r0_cnt; d0s = d0_cnt;
    i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 6'h11; i_req0_wdata = 8'hA5;
    tick();
    check("ab_ready0", o_req0_ready, 1);
    check("ab_txcmd",  o_data, 8'h91);
    i_req0_valid = 0; i_dir = 1;
    tick();
    check("ab1_data", o_data, 8'h00);
    check("ab1_busy", o_busy, 1);
    i_dir = 0;
    tick();
    check("ab1_wait", o_data, 8'h00);    // DIR low only one cycle so far
    tick();
    check("ab1_reissue", o_data, 8'h91);
    i_dir = 1;
    tick();
    check("ab2_data", o_data, 8'h00);
    i_dir = 0;
    tick();
    check("ab2_wait", o_data, 8'h00);
    tick();
    check("ab2_reissue", o_data, 8'h91);
    i_nxt = 1;
    tick();
    check("ab_wdata", o_data, 8'hA5);
    tick();
    check("ab_stp", o_stp, 1);
    i_nxt = 0;
    tick();
    check("ab_done0", o_req0_done, 1);
    check("ab_ready_once", r0_cnt - r0s, 1);
    check("ab_done_once",  d0_cnt - d0s, 1);

    // ------- DIR (with NXT) in every CMD -> err after 4th abort -------
    r1s = r1_cnt; d1s = d1_cnt; e1s = e1_cnt; stps = stp_cnt;
    cmds = 0; err_busy = 1'b1;
    i_req1_valid = 1; i_req1_we = 1; i_req1_addr = 6'h22; i_req1_wdata = 8'h77;
    tick();
    check("mr_ready1", o_req1_ready, 1);
    i_req1_valid = 0;
    for (int i = 0; i < 60 && e1_cnt == e1s; i++) begin
      if (o_data == 8'hA2) cmds++;
      i_dir = (o_data == 8'hA2);
      i_nxt = i_dir;                     // abort must win over NXT
      tick();
      if (o_req1_err) err_busy = o_busy;
    end
    i_dir = 0; i_nxt = 0;
    check("mr_attempts",   cmds, 4);
    check("mr_err_once",   e1_cnt - e1s, 1);
    check("mr_busy_fall",  err_busy, 0);
    check("mr_no_done",    d1_cnt - d1s, 0);
    check("mr_no_stp",     stp_cnt - stps, 0);
    check("mr_ready_once", r1_cnt - r1s, 1);
    tick();
    check("mr_err_pulse", o_req1_err, 0);
    tick();

    // ---------------- reset during WDATA ----------------
    d0s = d0_cnt;
    i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 6'h3F; i_req0_wdata = 8'hFF;
    tick();
    check("rw_txcmd", o_data, 8'hBF);
    i_req0_valid = 0; i_nxt = 1;
    tick();
    check("rw_wdata", o_data, 8'hFF);
    i_rst_n = 0;
    #1;
    check("rw_data",  o_data, 8'h00);
    check("rw_busy",  o_busy, 0);
    check("rw_stp",   o_stp, 0);
    check("rw_rdata1", o_req1_rdata, 8'h00);
    i_nxt = 0;
    tick(); tick();
    check("rw_no_done", d0_cnt - d0s, 0);
    check("rw_no_stp",  o_stp, 0);
    i_rst_n = 1;
    tick();
    // Pointer is back to favouring req0.
    d0s = d0_cnt;
    i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 6'h05; i_req0_wdata = 8'h3C;
    i_req1_valid = 1; i_req1_we = 1; i_req1_addr = 6'h06; i_req1_wdata = 8'h3D;
    tick();
    check("rw_post_grant", {o_req0_ready, o_req1_ready}, 2'b10);
    check("rw_post_txcmd", o_data, 8'h85);
    i_req0_valid = 0; i_req1_valid = 0; i_nxt = 1;
    for (int i = 0; i < 20 && d0_cnt == d0s; i++) tick();
    i_nxt = 0;
    check("rw_post_done", d0_cnt - d0s, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
